// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipe_ctrl_pkg: shared hazard FSM encodings, excluded registers and defaults
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_MUL_BUSY = 2'd1,
    HZ_MEM_WAIT = 2'd2
  } hz_state_t;
  localparam logic [3:0] REG_ZERO = 4'd0;
  localparam logic [3:0] REG_PC = 4'd15;
  localparam int MUL_CYCLES_DEF = 3;
  localparam int MEM_TIMEOUT_DEF = 64;
  localparam logic [1:0] FWD_NONE = 2'd0;
  localparam logic [1:0] FWD_EX_MEM = 2'd1;
  localparam logic [1:0] FWD_MEM_WB = 2'd2;
  // R0 and R15 are never forwarded, so they never create a load-use hazard
  function automatic logic hz_reg_ok(input logic [3:0] r);
    return (r != REG_ZERO) && (r != REG_PC);
  endfunction
endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: pipeline-side hazard inputs and stall/flush/status outputs
interface pipeline_hazard_ctrl_if #(parameter int CNT_W = 32);
  logic [3:0] id_rn;
  logic [3:0] id_rm;
  logic id_rn_used;
  logic id_rm_used;
  logic [3:0] ex_rd;
  logic ex_mem_read;
  logic ex_mul_start;
  logic ex_branch_taken;
  logic mem_busy;
  logic pc_stall;
  logic if_id_stall;
  logic if_id_flush;
  logic id_ex_stall;
  logic id_ex_flush;
  logic ex_mem_stall;
  logic ex_mem_flush;
  logic mem_wb_flush;
  logic [1:0] state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic mem_timeout_err;
  modport master (
    output id_rn, id_rm, id_rn_used, id_rm_used, ex_rd, ex_mem_read, ex_mul_start,
           ex_branch_taken, mem_busy,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall,
           ex_mem_flush, mem_wb_flush, state, stall_cnt, flush_cnt, mem_timeout_err
  );
  modport slave (
    input  id_rn, id_rm, id_rn_used, id_rm_used, ex_rd, ex_mem_read, ex_mul_start,
           ex_branch_taken, mem_busy,
    output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall,
           ex_mem_flush, mem_wb_flush, state, stall_cnt, flush_cnt, mem_timeout_err
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_load_use.sv
// hazard_load_use_detect: flags an ID operand that depends on the load currently in EX
module hazard_load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [3:0] i_id_rn,
  input  logic [3:0] i_id_rm,
  input  logic       i_id_rn_used,
  input  logic       i_id_rm_used,
  input  logic [3:0] i_ex_rd,
  input  logic       i_ex_mem_read,
  output logic       o_load_use_hazard
);
  assign o_load_use_hazard = i_ex_mem_read && hz_reg_ok(i_ex_rd) &&
                             ((i_id_rn_used && i_id_rn == i_ex_rd) ||
                              (i_id_rm_used && i_id_rm == i_ex_rd));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for load-use, multiply, memory wait and branches
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES  = MUL_CYCLES_DEF,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = 32
) (
  input logic clk,
  input logic rst_n,
  pipeline_hazard_ctrl_if.slave bus
);
  localparam int MUL_W = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES) : 1;
  localparam int TO_W = $clog2(MEM_TIMEOUT + 1);
  hz_state_t r_state;
  logic [MUL_W-1:0] r_mul_cnt;
  logic [TO_W-1:0] r_to_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic r_err;
  logic w_load_use;
  logic w_mem;
  logic w_mul;
  logic w_run;
  logic w_br;
  logic w_ldu;
  logic w_pc_stall;
  logic w_to_full;
  hazard_load_use_detect u_lu (
    .i_id_rn          (bus.id_rn),
    .i_id_rm          (bus.id_rm),
    .i_id_rn_used     (bus.id_rn_used),
    .i_id_rm_used     (bus.id_rm_used),
    .i_ex_rd          (bus.ex_rd),
    .i_ex_mem_read    (bus.ex_mem_read),
    .o_load_use_hazard(w_load_use)
  );
  // A pending multiply still owns EX on the cycle memory releases, so upstream keeps holding
  assign w_mem = rst_n && bus.mem_busy;
  assign w_mul = rst_n && !bus.mem_busy &&
                 (r_state == HZ_MUL_BUSY || (r_state == HZ_MEM_WAIT && r_mul_cnt != '0));
  assign w_run = rst_n && !bus.mem_busy && !w_mul;
  assign w_br = w_run && bus.ex_branch_taken;
  assign w_ldu = w_run && !bus.ex_branch_taken && w_load_use;
  assign w_pc_stall = w_mem || w_mul || w_ldu;
  assign w_to_full = r_to_cnt == TO_W'(MEM_TIMEOUT);
  assign bus.pc_stall = w_pc_stall;
  assign bus.if_id_stall = w_pc_stall;
  assign bus.if_id_flush = w_br;
  assign bus.id_ex_stall = w_mem || w_mul;
  assign bus.id_ex_flush = w_br || w_ldu;
  assign bus.ex_mem_stall = w_mem;
  assign bus.ex_mem_flush = w_mul;
  assign bus.mem_wb_flush = w_mem;
  assign bus.state = r_state;
  assign bus.stall_cnt = r_stall_cnt;
  assign bus.flush_cnt = r_flush_cnt;
  assign bus.mem_timeout_err = r_err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= HZ_RUN;
      r_mul_cnt <= '0;
      r_to_cnt <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(w_pc_stall);
      r_flush_cnt <= r_flush_cnt + CNT_W'(w_br);
      if (bus.mem_busy) begin
        r_state <= HZ_MEM_WAIT;
        r_to_cnt <= w_to_full ? r_to_cnt : r_to_cnt + 1'b1;
        r_err <= r_err || w_to_full;
      end else begin
        r_to_cnt <= '0;
        if (r_state == HZ_MUL_BUSY) begin
          r_mul_cnt <= r_mul_cnt - 1'b1;
          r_state <= (r_mul_cnt == MUL_W'(1)) ? HZ_RUN : HZ_MUL_BUSY;
        end else if (w_mul) begin
          r_state <= HZ_MUL_BUSY;
        end else if (bus.ex_mul_start && MUL_CYCLES > 1) begin
          r_mul_cnt <= MUL_W'(MUL_CYCLES - 1);
          r_state <= HZ_MUL_BUSY;
        end else begin
          r_state <= HZ_RUN;
        end
      end
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed and randomized checks against a cycle-level hazard model
module tb_pipeline_hazard_ctrl;
  localparam int MC = 3;
  localparam int MT = 4;
  localparam int CW = 32;
  localparam logic [7:0] O_NONE = 8'h00;
  localparam logic [7:0] O_FREEZE = 8'b1101_0101;
  localparam logic [7:0] O_MUL = 8'b1101_0010;
  localparam logic [7:0] O_BR = 8'b0010_1000;
  localparam logic [7:0] O_LU = 8'b1100_1000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  int m_rem;
  int m_busy_run;
  bit m_frozen;
  bit m_err;
  logic [CW-1:0] m_stall;
  logic [CW-1:0] m_flush;
  always #5 clk = ~clk;
  pipeline_hazard_ctrl_if #(.CNT_W(CW)) bus ();
  pipeline_hazard_ctrl #(.MUL_CYCLES(MC), .MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );
  function automatic logic [7:0] act_out();
    return {bus.pc_stall, bus.if_id_stall, bus.if_id_flush, bus.id_ex_stall,
            bus.id_ex_flush, bus.ex_mem_stall, bus.ex_mem_flush, bus.mem_wb_flush};
  endfunction
  function automatic bit lu_model();
    return bus.ex_mem_read && bus.ex_rd != 4'd0 && bus.ex_rd != 4'd15 &&
           ((bus.id_rn_used && bus.id_rn == bus.ex_rd) || (bus.id_rm_used && bus.id_rm == bus.ex_rd));
  endfunction
  // Expected stage controls: the outstanding multiply cycles, the inputs, and the priority order
  function automatic logic [7:0] exp_out();
    if (!rst_n) return O_NONE;
    if (bus.mem_busy) return O_FREEZE;
    if (m_rem > 0) return O_MUL;
    if (bus.ex_branch_taken) return O_BR;
    if (lu_model()) return O_LU;
    return O_NONE;
  endfunction
  function automatic logic [1:0] exp_state();
    return m_frozen ? 2'd2 : (m_rem > 0 ? 2'd1 : 2'd0);
  endfunction
  function automatic logic [2*CW+2:0] act_regs();
    return {bus.state, bus.stall_cnt, bus.flush_cnt, bus.mem_timeout_err};
  endfunction
  function automatic logic [2*CW+2:0] exp_regs();
    return {exp_state(), m_stall, m_flush, m_err};
  endfunction
  task automatic model_reset();
    m_rem = 0;
    m_busy_run = 0;
    m_frozen = 0;
    m_err = 0;
    m_stall = '0;
    m_flush = '0;
  endtask
  task automatic model_update();
    logic [7:0] e;
    e = exp_out();
    m_stall += CW'(e[7]);
    m_flush += CW'(e[5]);
    if (bus.mem_busy) begin
      if (m_busy_run >= MT) m_err = 1;
      m_busy_run++;
    end else begin
      m_busy_run = 0;
      if (m_rem > 0) begin
        if (!m_frozen) m_rem--;
      end else if (bus.ex_mul_start && MC > 1) m_rem = MC - 1;
    end
    m_frozen = bus.mem_busy;
  endtask
  task automatic set_in(input logic [3:0] rn, rm, input logic rnu, rmu, input logic [3:0] rd,
                        input logic mr, ms, bt, mb);
    bus.id_rn = rn;
    bus.id_rm = rm;
    bus.id_rn_used = rnu;
    bus.id_rm_used = rmu;
    bus.ex_rd = rd;
    bus.ex_mem_read = mr;
    bus.ex_mul_start = ms;
    bus.ex_branch_taken = bt;
    bus.mem_busy = mb;
  endtask
  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic tick();
    model_update();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask
  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    set_in(3, 3, 1, 1, 3, 1, 1, 1, 1);
    @(negedge clk);
    #1;
    n_tests++;
    if (act_out() !== O_NONE) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected %b", act_out(), O_NONE);
    end
    n_tests++;
    if (act_regs() !== '0) begin
      n_fail++;
      $display("FAIL reset_regs: got %h expected 0", act_regs());
    end
    do_reset();
    tick();
    n_tests++;
    if (act_regs() !== '0) begin
      n_fail++;
      $display("FAIL reset_idle_regs: got %h expected 0", act_regs());
    end
  endtask
  task automatic test_load_use();
    logic [3:0] rn[5] = '{4'd3, 4'd0, 4'd15, 4'd5, 4'd9};
    logic [3:0] rm[5] = '{4'd0, 4'd0, 4'd15, 4'd7, 4'd2};
    logic rnu[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic rmu[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [3:0] rd[5] = '{4'd3, 4'd0, 4'd15, 4'd7, 4'd9};
    bit hz[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [CW-1:0] want = '0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_in(rn[i], rm[i], rnu[i], rmu[i], rd[i], 1, 0, 0, 0);
      #1;
      n_tests++;
      if (act_out() !== (hz[i] ? O_LU : O_NONE)) begin
        n_fail++;
        $display("FAIL load_use_out[%0d]: got %b expected %b", i, act_out(), hz[i] ? O_LU : O_NONE);
      end
      tick();
      want += CW'(hz[i]);
      n_tests++;
      if (bus.stall_cnt !== want || bus.state !== 2'd0) begin
        n_fail++;
        $display("FAIL load_use_cnt[%0d]: got cnt=%0d state=%0d expected cnt=%0d state=0",
                 i, bus.stall_cnt, bus.state, want);
      end
    end
  endtask
  task automatic test_multiply();
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
    #1;
    n_tests++;
    if (act_out() !== O_NONE) begin
      n_fail++;
      $display("FAIL mul_start_out: got %b expected %b", act_out(), O_NONE);
    end
    tick();
    idle();
    for (int i = 0; i < MC - 1; i++) begin
      #1;
      n_tests++;
      if (bus.state !== 2'd1 || act_out() !== O_MUL) begin
        n_fail++;
        $display("FAIL mul_busy[%0d]: got state=%0d out=%b expected state=1 out=%b",
                 i, bus.state, act_out(), O_MUL);
      end
      tick();
    end
    n_tests++;
    if (bus.state !== 2'd0 || act_out() !== O_NONE || bus.stall_cnt !== CW'(MC - 1)) begin
      n_fail++;
      $display("FAIL mul_done: got state=%0d out=%b cnt=%0d expected state=0 out=0 cnt=%0d",
               bus.state, act_out(), bus.stall_cnt, MC - 1);
    end
  endtask
  task automatic test_branch_lu();
    do_reset();
    set_in(6, 6, 1, 1, 6, 1, 0, 1, 0);
    #1;
    n_tests++;
    if (act_out() !== O_BR) begin
      n_fail++;
      $display("FAIL branch_lu_out: got %b expected %b", act_out(), O_BR);
    end
    tick();
    idle();
    n_tests++;
    if (bus.flush_cnt !== CW'(1) || bus.stall_cnt !== '0) begin
      n_fail++;
      $display("FAIL branch_lu_cnt: got flush=%0d stall=%0d expected flush=1 stall=0",
               bus.flush_cnt, bus.stall_cnt);
    end
  endtask
  task automatic test_mem_in_mul();
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    idle();
    tick();
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 1, 1, 1);
      #1;
      n_tests++;
      if (act_out() !== O_FREEZE) begin
        n_fail++;
        $display("FAIL mem_freeze_out[%0d]: got %b expected %b", i, act_out(), O_FREEZE);
      end
      tick();
      n_tests++;
      if (bus.state !== 2'd2) begin
        n_fail++;
        $display("FAIL mem_freeze_state[%0d]: got %0d expected 2", i, bus.state);
      end
    end
    idle();
    for (int i = 0; i < 2; i++) begin
      #1;
      n_tests++;
      if (act_out() !== O_MUL) begin
        n_fail++;
        $display("FAIL mem_release_out[%0d]: got %b expected %b", i, act_out(), O_MUL);
      end
      tick();
      n_tests++;
      if (bus.state !== (i == 0 ? 2'd1 : 2'd0)) begin
        n_fail++;
        $display("FAIL mem_release_state[%0d]: got %0d expected %0d", i, bus.state, i == 0 ? 1 : 0);
      end
    end
    n_tests++;
    if (bus.stall_cnt !== CW'(6) || bus.flush_cnt !== '0) begin
      n_fail++;
      $display("FAIL mem_in_mul_cnt: got stall=%0d flush=%0d expected stall=6 flush=0",
               bus.stall_cnt, bus.flush_cnt);
    end
  endtask
  task automatic test_timeout();
    do_reset();
    for (int b = MT; b <= MT + 1; b++) begin
      for (int i = 0; i < b; i++) begin
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
      end
      n_tests++;
      if (bus.mem_timeout_err !== (b > MT)) begin
        n_fail++;
        $display("FAIL timeout_burst%0d: got %b expected %b", b, bus.mem_timeout_err, b > MT);
      end
      idle();
      tick();
      tick();
      n_tests++;
      if (bus.mem_timeout_err !== (b > MT) || bus.state !== 2'd0) begin
        n_fail++;
        $display("FAIL timeout_after%0d: got err=%b state=%0d expected err=%b state=0",
                 b, bus.mem_timeout_err, bus.state, b > MT);
      end
    end
  endtask
  task automatic test_async_reset();
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    idle();
    tick();
    n_tests++;
    if (bus.state !== 2'd1 || bus.stall_cnt !== CW'(1)) begin
      n_fail++;
      $display("FAIL async_pre: got state=%0d cnt=%0d expected state=1 cnt=1", bus.state, bus.stall_cnt);
    end
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if (act_out() !== O_NONE || act_regs() !== '0) begin
      n_fail++;
      $display("FAIL async_assert: got out=%b regs=%h expected 0", act_out(), act_regs());
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    tick();
    n_tests++;
    if (act_regs() !== '0 || act_out() !== O_NONE) begin
      n_fail++;
      $display("FAIL async_release: got out=%b regs=%h expected 0", act_out(), act_regs());
    end
  endtask
  task automatic test_random();
    int burst = 0;
    logic [3:0] rd;
    logic mb;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rd = 4'($urandom_range(0, 15));
      if (burst > 0) begin
        mb = 1'b1;
        burst--;
      end else if ($urandom_range(0, 11) == 0) begin
        mb = 1'b1;
        burst = $urandom_range(0, 5);
      end else mb = 1'b0;
      set_in($urandom_range(0, 1) ? rd : 4'($urandom_range(0, 15)),
             $urandom_range(0, 2) == 0 ? rd : 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rd,
             1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
             $urandom_range(0, 5) == 0, mb);
      #1;
      n_tests++;
      if (act_out() !== exp_out()) begin
        n_fail++;
        $display("FAIL rand_out[%0d]: got %b expected %b", c, act_out(), exp_out());
      end
      tick();
      n_tests++;
      if (act_regs() !== exp_regs()) begin
        n_fail++;
        $display("FAIL rand_regs[%0d]: got %h expected %h", c, act_regs(), exp_regs());
      end
    end
  endtask
  initial begin
    model_reset();
    idle();
    test_reset();
    test_load_use();
    test_multiply();
    test_branch_lu();
    test_mem_in_mul();
    test_timeout();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage ARM pipeline; works alongside the EX-stage forwarding logic. Resolves the hazards forwarding cannot cover: load-use, multi-cycle multiply occupancy of EX, data-memory wait states and taken-branch flushes. Drives per-stage stall/flush enables, and keeps performance counters plus a sticky memory-timeout flag.

Parameters:
MUL_CYCLES, 3, total EX occupancy of a multiply (>=1); stalls upstream for MUL_CYCLES-1 cycles
MEM_TIMEOUT, 64, consecutive mem_busy cycles tolerated before mem_timeout_err sets
CNT_W, 32, width of performance counters

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
id_rn  in  4  ID-stage operand A register
id_rm  in  4  ID-stage operand B register
id_rn_used  in  1  ID instruction reads id_rn
id_rm_used  in  1  ID instruction reads id_rm
ex_rd  in  4  EX-stage destination
ex_mem_read  in  1  EX instruction is a load
ex_mul_start  in  1  multi-cycle multiply entered EX this cycle
ex_branch_taken  in  1  EX resolved a taken branch
mem_busy  in  1  data memory not ready; MEM result not available
pc_stall  out  1  hold PC
if_id_stall  out  1  hold IF/ID
if_id_flush  out  1  clear IF/ID to NOP
id_ex_stall  out  1  hold ID/EX
id_ex_flush  out  1  load bubble into ID/EX
ex_mem_stall  out  1  hold EX/MEM
ex_mem_flush  out  1  load bubble into EX/MEM
mem_wb_flush  out  1  load bubble into MEM/WB
state  out  2  current FSM state (debug)
stall_cnt  out  CNT_W  cycles with pc_stall=1
flush_cnt  out  CNT_W  branch flush events
mem_timeout_err  out  1  sticky timeout flag

Behaviour:
- FSM states: RUN=0, MUL_BUSY=1, MEM_WAIT=2. Encodings are fixed; they are shared via the package.
- Reset (rst_n=0, async): state=RUN; mul counter, timeout counter, stall_cnt and flush_cnt = 0; mem_timeout_err=0; all stall/flush outputs 0 regardless of inputs.
- Stall/flush outputs are combinational functions of state and the current inputs (0-cycle latency). State, counters and flags update on posedge clk.
- Hazard register qualifier: R0 and R15 never create a load-use hazard. This is consistent with the forwarding exclusion.
- Priority when events coincide: mem freeze > multiply busy > branch flush > load-use.
- Memory freeze (mem_busy=1, any state):
  - pc_stall, if_id_stall, id_ex_stall, ex_mem_stall = 1; mem_wb_flush=1; every other flush = 0.
  - state enters/stays MEM_WAIT. The timeout counter increments, saturating at MEM_TIMEOUT.
  - Once the counter has reached MEM_TIMEOUT and mem_busy is still 1, mem_timeout_err sets and stays set until reset.
  - When mem_busy=0, the timeout counter clears. Next state is MUL_BUSY if the multiply count is nonzero, otherwise RUN.
  - The multiply count holds while frozen. ex_mul_start is ignored while mem_busy=1 (EX is frozen, so the source re-asserts it).
- Multiply:
  - In RUN with ex_mul_start=1, mem_busy=0 and MUL_CYCLES>1: load count = MUL_CYCLES-1, go to MUL_BUSY. This cycle is not itself stalled.
  - In MUL_BUSY: pc_stall, if_id_stall, id_ex_stall = 1 and ex_mem_flush=1. Count decrements each cycle; at count==1, next state is RUN.
  - MUL_CYCLES=1 means no stall and no state change.
- Branch flush (RUN, ex_branch_taken=1, no higher-priority event): if_id_flush=1, id_ex_flush=1, no stalls, flush_cnt+1. This overrides any load-use hazard seen in ID, since that instruction is wrong-path.
- Load-use (RUN, no higher-priority event, ex_mem_read=1, ex_rd∉{0,15}, and (id_rn_used & id_rn==ex_rd) or (id_rm_used & id_rm==ex_rd)): pc_stall=1, if_id_stall=1, id_ex_flush=1 for exactly one cycle. The next cycle the load is in MEM and forwarding resolves the dependency.
- Counters: stall_cnt increments on every cycle with pc_stall=1; flush_cnt increments on every branch flush. Both wrap modulo 2^CNT_W.

Decomposition:
- Package pipe_ctrl_pkg holds the FSM state encodings (HZ_RUN, HZ_MUL_BUSY, HZ_MEM_WAIT), the excluded registers (REG_ZERO=0, REG_PC=15), and the default MUL_CYCLES and MEM_TIMEOUT. The existing FWD_* constants stay where they are.
- One natural sub-module: hazard_load_use_detect, a combinational comparator producing load_use_hazard. The FSM, counters and output muxing live in the top level.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=3, id_rn=3, id_rn_used=1 -> one cycle of pc_stall=1, if_id_stall=1, id_ex_flush=1; stall_cnt=1. Same stimulus with ex_rd=0 or 15 -> no stall.
- Multiply, MUL_CYCLES=3: ex_mul_start pulse -> state=1 for 2 cycles with pc/if_id/id_ex stall and ex_mem_flush, then RUN; stall_cnt=2.
- Branch + load-use in the same cycle -> if_id_flush=1, id_ex_flush=1, pc_stall=0; flush_cnt=1.
- mem_busy held 3 cycles during MUL_BUSY with count=1 -> full freeze with mem_wb_flush=1; on release returns to MUL_BUSY for 1 cycle, then RUN.
- mem_busy held MEM_TIMEOUT+1 cycles (MEM_TIMEOUT=4) -> mem_timeout_err rises and stays 1 after mem_busy drops.
- Async reset asserted mid-MUL_BUSY -> all outputs 0 immediately; state=0, counters=0 after release.
